shift16_sequencer: RTL and testbench

- Multi-cycle 16-bit shift unit for the RISC16 datapath. Sits directly around the 8-bit left barrel shifter: it feeds the shifter's 8-bit input and 3-bit magnitude, and consumes its output.
- Decomposes each 16-bit SLL/SRL/SRA into three sequential 8-bit shifter passes.
- Returns the result to the execute stage over a valid/ready handshake.

---
 rtl/shift16_sequencer.sv | 174 +++++++++++++++++
 tb/tb_shift16_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift16_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift16_sequencer
// Purpose  : Multi-cycle 16-bit SLL/SRL/SRA built from three passes through
//            an external 8-bit left barrel shifter (low byte, high byte, then
//            the bits that spill from the low byte into the high byte).
//            Right shifts reuse the left shifter by bit-reversing the operand
//            on entry and the result on exit.
// Ports    : clk, rst (async, active-high)
//            start_valid/start_ready, operand[15:0], amount[3:0], op[1:0]
//            result_valid/result_ready, result[15:0], result_zero
//            bs_ip[7:0], bs_shift_mag[2:0] -> shifter; bs_op[7:0] <- shifter
// Revision : 1.0  initial release
// ============================================================================
module shift16_sequencer #(
  parameter bit SRA_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [15:0] operand,
  input  logic [3:0]  amount,
  input  logic [1:0]  op,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [15:0] result,
  output logic        result_zero,
  output logic [7:0]  bs_ip,
  output logic [2:0]  bs_shift_mag,
  input  logic [7:0]  bs_op
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PASS_LO    = 3'd1,
    PASS_HI    = 3'd2,
    PASS_SPILL = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t      state_q;
  logic [15:0] w_q;          // working word, bit-reversed for right shifts
  logic [3:0]  n_q;          // full shift distance
  logic [1:0]  op_q;
  logic        sign_q;
  logic [7:0]  p0_q;
  logic [7:0]  p1_q;
  logic [15:0] result_q;
  logic        result_zero_q;
  logic        result_valid_q;

  logic [15:0] result_d;
  logic [7:0]  spill_s;
  logic [15:0] l_word;
  logic [2:0]  m;
  logic        right_q;

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  function automatic logic [15:0] rev16(input logic [15:0] x);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = x[15-i];
    return r;
  endfunction

  function automatic logic is_right(input logic [1:0] o);
    return (o == 2'b01) || (o == 2'b10);
  endfunction

  assign m       = n_q[2:0];
  assign right_q = is_right(op_q);

  // Shifter drive is decoded straight from the state register, so an
  // asynchronous reset zeroes it immediately.
  always_comb begin
    bs_ip        = 8'h00;
    bs_shift_mag = 3'd0;
    case (state_q)
      PASS_LO: begin
        bs_ip        = w_q[7:0];
        bs_shift_mag = m;
      end
      PASS_HI: begin
        bs_ip        = w_q[15:8];
        bs_shift_mag = m;
      end
      PASS_SPILL: begin
        // rev8(rev8(x) << (8-m)) == x >> (8-m): the bits of the low byte that
        // cross into the high byte. (8-m) mod 8 is just -m in three bits.
        bs_ip        = rev8(w_q[7:0]);
        bs_shift_mag = 3'd0 - m;
      end
      default: begin
        bs_ip        = 8'h00;
        bs_shift_mag = 3'd0;
      end
    endcase
  end

  // Final combine, only meaningful while in PASS_SPILL.
  always_comb begin
    // With m==0 the shifter sees magnitude 0 and would return the whole low
    // byte, which must not leak into the high byte.
    spill_s  = (m != 3'd0) ? rev8(bs_op) : 8'h00;
    l_word   = n_q[3] ? {p0_q, 8'h00} : {p1_q | spill_s, p0_q};
    result_d = right_q ? rev16(l_word) : l_word;
    if (SRA_EN && (op_q == 2'b10) && sign_q) begin
      result_d = result_d | ~(16'hFFFF >> n_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      w_q            <= 16'h0000;
      n_q            <= 4'd0;
      op_q           <= 2'b00;
      sign_q         <= 1'b0;
      p0_q           <= 8'h00;
      p1_q           <= 8'h00;
      result_q       <= 16'h0000;
      result_zero_q  <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            w_q     <= is_right(op) ? rev16(operand) : operand;
            n_q     <= amount;
            op_q    <= op;
            sign_q  <= operand[15];
            state_q <= PASS_LO;
          end
        end
        PASS_LO: begin
          p0_q    <= bs_op;
          state_q <= PASS_HI;
        end
        PASS_HI: begin
          p1_q    <= bs_op;
          state_q <= PASS_SPILL;
        end
        PASS_SPILL: begin
          result_q       <= result_d;
          result_zero_q  <= (result_d == 16'h0000);
          result_valid_q <= 1'b1;
          state_q        <= DONE;
        end
        DONE: begin
          // No accept here even if the result leaves this cycle.
          if (result_ready) begin
            result_valid_q <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign start_ready  = (state_q == IDLE);
  assign result       = result_q;
  assign result_zero  = result_zero_q;
  assign result_valid = result_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_shift16_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift16_sequencer
// Purpose  : Self-checking bench for shift16_sequencer. Two instances run in
//            lockstep (SRA_EN=1 and SRA_EN=0) around ideal 8-bit shifters and
//            are compared against plain 16-bit shift arithmetic.
// Revision : 1.0  initial release
// ============================================================================
module tb_shift16_sequencer;

  logic        clk;
  logic        rst;
  logic        start_valid;
  logic [15:0] operand;
  logic [3:0]  amount;
  logic [1:0]  op;
  logic        result_ready;

  logic        start_ready,  start_ready_n;
  logic        result_valid, result_valid_n;
  logic [15:0] result,       result_n;
  logic        result_zero,  result_zero_n;
  logic [7:0]  bs_ip,        bs_ip_n;
  logic [2:0]  bs_shift_mag, bs_shift_mag_n;
  logic [7:0]  bs_op,        bs_op_n;

  int vectors     = 0;
  int miscompares = 0;

  // Ideal 8-bit left barrel shifters, zero fill.
  assign bs_op   = 8'(bs_ip << bs_shift_mag);
  assign bs_op_n = 8'(bs_ip_n << bs_shift_mag_n);

  shift16_sequencer #(.SRA_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .operand(operand), .amount(amount), .op(op),
    .result_valid(result_valid), .result_ready(result_ready),
    .result(result), .result_zero(result_zero),
    .bs_ip(bs_ip), .bs_shift_mag(bs_shift_mag), .bs_op(bs_op)
  );

  shift16_sequencer #(.SRA_EN(1'b0)) dut_n (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready_n),
    .operand(operand), .amount(amount), .op(op),
    .result_valid(result_valid_n), .result_ready(result_ready),
    .result(result_n), .result_zero(result_zero_n),
    .bs_ip(bs_ip_n), .bs_shift_mag(bs_shift_mag_n), .bs_op(bs_op_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: straightforward 16-bit shifts.
  function automatic logic [15:0] model(input logic [15:0] a, input int n,
                                        input logic [1:0] o, input bit sra);
    logic signed [15:0] s;
    s = a;
    case (o)
      2'b01:   return a >> n;
      2'b10:   return sra ? 16'(s >>> n) : (a >> n);
      default: return a << n;
    endcase
  endfunction

  // Drives one full request with result_ready held high. Entered and left at
  // posedge+1 with the DUT idle. Inputs are scrambled after accept and
  // start_valid is kept asserted while busy to show both are ignored.
  task automatic run_op(input logic [15:0] a, input logic [3:0] n, input logic [1:0] o,
                        output logic [15:0] r1, output logic [15:0] r0,
                        output logic z1, output logic z0,
                        output logic early, output logic v,
                        output logic [2:0] m0, output logic [2:0] m1, output logic [2:0] m2,
                        output logic rdy_after);
    start_valid  = 1'b1;
    operand      = a;
    amount       = n;
    op           = o;
    result_ready = 1'b1;
    @(posedge clk); #1;
    operand = 16'($urandom);
    amount  = 4'($urandom);
    op      = 2'($urandom);
    early = result_valid | result_valid_n | start_ready; m0 = bs_shift_mag;
    @(posedge clk); #1;
    early = early | result_valid | result_valid_n | start_ready; m1 = bs_shift_mag;
    @(posedge clk); #1;
    early = early | result_valid | result_valid_n | start_ready; m2 = bs_shift_mag;
    @(posedge clk); #1;
    v  = result_valid & result_valid_n & ~start_ready & ~start_ready_n;
    r1 = result; r0 = result_n; z1 = result_zero; z0 = result_zero_n;
    start_valid = 1'b0;
    @(posedge clk); #1;
    rdy_after = start_ready & start_ready_n & ~result_valid;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    vectors++;
    if ({start_ready, result_valid, result, result_zero, bs_ip, bs_shift_mag} !== {1'b1, 1'b0, 16'h0, 1'b0, 8'h0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b v=%b res=%h z=%b ip=%h mag=%0d, want rdy=1 v=0 res=0000 z=0 ip=00 mag=0",
               start_ready, result_valid, result, result_zero, bs_ip, bs_shift_mag);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [3:0]  n;
    logic [1:0]  o;
    logic [15:0] e1;
    logic [15:0] e0;
  } vec_t;

  task automatic test_directed;
    vec_t tbl[10];
    logic [15:0] r1, r0;
    logic z1, z0, early, v, rdy;
    logic [2:0] m0, m1, m2;
    logic [2:0] em;
    tbl[0] = '{16'h00FF, 4'd4,  2'b00, 16'h0FF0, 16'h0FF0};
    tbl[1] = '{16'h1234, 4'd12, 2'b00, 16'h4000, 16'h4000};
    tbl[2] = '{16'h0100, 4'd8,  2'b00, 16'h0000, 16'h0000};
    tbl[3] = '{16'h8001, 4'd1,  2'b01, 16'h4000, 16'h4000};
    tbl[4] = '{16'h8001, 4'd1,  2'b10, 16'hC000, 16'h4000};
    tbl[5] = '{16'h8000, 4'd15, 2'b10, 16'hFFFF, 16'h0001};
    tbl[6] = '{16'hA5C3, 4'd0,  2'b00, 16'hA5C3, 16'hA5C3};
    tbl[7] = '{16'hA5C3, 4'd0,  2'b01, 16'hA5C3, 16'hA5C3};
    tbl[8] = '{16'hA5C3, 4'd0,  2'b10, 16'hA5C3, 16'hA5C3};
    tbl[9] = '{16'hA5C3, 4'd0,  2'b11, 16'hA5C3, 16'hA5C3};
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].n, tbl[i].o, r1, r0, z1, z0, early, v, m0, m1, m2, rdy);
      em = tbl[i].n[2:0];
      vectors++;
      if ({r1, r0} !== {tbl[i].e1, tbl[i].e0}) begin
        miscompares++;
        $display("FAIL dir_result[%0d]: got %h/%h, want %h/%h", i, r1, r0, tbl[i].e1, tbl[i].e0);
      end
      vectors++;
      if ({z1, z0} !== {tbl[i].e1 == 16'h0, tbl[i].e0 == 16'h0}) begin
        miscompares++;
        $display("FAIL dir_zero[%0d]: got %b/%b, want %b/%b", i, z1, z0, tbl[i].e1 == 16'h0, tbl[i].e0 == 16'h0);
      end
      vectors++;
      if ({early, v, rdy} !== 3'b011) begin
        miscompares++;
        $display("FAIL dir_latency[%0d]: got early=%b valid=%b idle_after=%b, want 0 1 1", i, early, v, rdy);
      end
      vectors++;
      if ({m0, m1, m2} !== {em, em, 3'((8 - int'(em)) % 8)}) begin
        miscompares++;
        $display("FAIL dir_mag[%0d]: got %0d,%0d,%0d, want %0d,%0d,%0d", i, m0, m1, m2, em, em, (8 - int'(em)) % 8);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] held;
    // First request: SLL 16'h0F0F by 3 -> 16'h7878.
    start_valid = 1'b1; operand = 16'h0F0F; amount = 4'd3; op = 2'b00; result_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if ({result_valid, result} !== {1'b1, 16'h7878}) begin
      miscompares++;
      $display("FAIL bp_first: got v=%b res=%h, want v=1 res=7878", result_valid, result);
    end
    held = 16'h7878;
    operand = 16'hFFFF; amount = 4'd1; op = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({result_valid, start_ready, result, result_zero} !== {1'b1, 1'b0, held, 1'b0}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got v=%b rdy=%b res=%h z=%b, want v=1 rdy=0 res=%h z=0",
                 i, result_valid, start_ready, result, result_zero, held);
      end
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({result_valid, start_ready, result} !== {1'b0, 1'b1, held}) begin
      miscompares++;
      $display("FAIL bp_release: got v=%b rdy=%b res=%h, want v=0 rdy=1 res=%h", result_valid, start_ready, result, held);
    end
    @(posedge clk); #1;
    vectors++;
    if (start_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_accept_next: got rdy=%b, want 0", start_ready);
    end
    start_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if ({result_valid, result} !== {1'b1, 16'h7FFF}) begin
      miscompares++;
      $display("FAIL bp_second: got v=%b res=%h, want v=1 res=7fff", result_valid, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    logic [15:0] r1, r0;
    logic z1, z0, early, v, rdy;
    logic [2:0] m0, m1, m2;
    logic seen_v;
    run_op(16'h00FF, 4'd4, 2'b00, r1, r0, z1, z0, early, v, m0, m1, m2, rdy);
    start_valid = 1'b1; operand = 16'h1234; amount = 4'd3; op = 2'b00; result_ready = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({bs_ip, bs_shift_mag} !== {8'h12, 3'd3}) begin
      miscompares++;
      $display("FAIL ar_pass_hi: got ip=%h mag=%0d, want ip=12 mag=3", bs_ip, bs_shift_mag);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({start_ready, result_valid, result, result_zero, bs_ip, bs_shift_mag} !== {1'b1, 1'b0, 16'h0, 1'b0, 8'h0, 3'd0}) begin
      miscompares++;
      $display("FAIL ar_immediate: got rdy=%b v=%b res=%h z=%b ip=%h mag=%0d, want 1 0 0000 0 00 0",
               start_ready, result_valid, result, result_zero, bs_ip, bs_shift_mag);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    seen_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      seen_v = seen_v | result_valid | ~start_ready;
    end
    vectors++;
    if (seen_v !== 1'b0) begin
      miscompares++;
      $display("FAIL ar_no_result: got stray activity=%b, want 0", seen_v);
    end
    run_op(16'h0001, 4'd15, 2'b00, r1, r0, z1, z0, early, v, m0, m1, m2, rdy);
    vectors++;
    if ({r1, v} !== {16'h8000, 1'b1}) begin
      miscompares++;
      $display("FAIL ar_after: got res=%h v=%b, want res=8000 v=1", r1, v);
    end
  endtask

  task automatic test_random;
    logic [15:0] a, r1, r0, e1, e0;
    logic [3:0]  n;
    logic [1:0]  o;
    logic z1, z0, early, v, rdy;
    logic [2:0] m0, m1, m2, em;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      n = 4'($urandom);
      o = 2'($urandom);
      if (i % 8 == 0) a = 16'h8000 | a;
      run_op(a, n, o, r1, r0, z1, z0, early, v, m0, m1, m2, rdy);
      e1 = model(a, int'(n), o, 1'b1);
      e0 = model(a, int'(n), o, 1'b0);
      em = n[2:0];
      vectors++;
      if ({r1, r0} !== {e1, e0}) begin
        miscompares++;
        $display("FAIL rnd_result[%0d] a=%h n=%0d op=%0d: got %h/%h, want %h/%h", i, a, n, o, r1, r0, e1, e0);
      end
      vectors++;
      if ({z1, z0} !== {e1 == 16'h0, e0 == 16'h0}) begin
        miscompares++;
        $display("FAIL rnd_zero[%0d]: got %b/%b, want %b/%b", i, z1, z0, e1 == 16'h0, e0 == 16'h0);
      end
      vectors++;
      if ({early, v, rdy} !== 3'b011) begin
        miscompares++;
        $display("FAIL rnd_latency[%0d]: got early=%b valid=%b idle_after=%b, want 0 1 1", i, early, v, rdy);
      end
      vectors++;
      if ({m0, m1, m2} !== {em, em, 3'((8 - int'(em)) % 8)}) begin
        miscompares++;
        $display("FAIL rnd_mag[%0d]: got %0d,%0d,%0d, want %0d,%0d,%0d", i, m0, m1, m2, em, em, (8 - int'(em)) % 8);
      end
    end
  endtask

  initial begin
    rst          = 1'b0;
    start_valid  = 1'b0;
    operand      = 16'h0000;
    amount       = 4'd0;
    op           = 2'b00;
    result_ready = 1'b0;
    test_reset;
    test_directed;
    test_backpressure;
    test_async_reset;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
